// File: rtl/jt1943_romarb.sv
// Four-client round-robin arbiter sharing one 16-bit SDRAM read port.
// Each grant fetches two words, assembles 32 bits and strobes the requesting cache.
module jt1943_romarb #(
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [AW-1:0] addr3,
  output logic [31:0]   dout,
  output logic [3:0]    we,
  output logic          sdram_req,
  output logic [AW-2:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [15:0]   sdram_din
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, DELIVER} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr, g, gnt, idx;
  logic          gnt_vld, match;
  logic [AW-3:0] lat_addr;
  logic [AW-1:0] addr_arr [4];
  logic          sdram_req_nxt;
  logic [3:0]    we_nxt;
  logic          unused_bits;

  assign addr_arr[0] = addr0;
  assign addr_arr[1] = addr1;
  assign addr_arr[2] = addr2;
  assign addr_arr[3] = addr3;
  assign unused_bits = ^{addr0[1:0], addr1[1:0], addr2[1:0], addr3[1:0]};

  assign sdram_addr = {lat_addr, 1'b0};
  assign match      = addr_arr[g][AW-1:2] == lat_addr;

  // Scan from the highest offset down so the closest set bit after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = ptr;
    idx     = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld)   state_nxt = ISSUE;
      ISSUE:   if (sdram_ack) state_nxt = WAIT_LO;
      WAIT_LO: if (data_rdy)  state_nxt = WAIT_HI;
      WAIT_HI: if (data_rdy)  state_nxt = DELIVER;
      DELIVER:                state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so that every port is a flop.
  always_comb begin
    sdram_req_nxt = state_nxt == ISSUE;
    we_nxt        = 4'b0;
    if (state == WAIT_HI && data_rdy && match) we_nxt = 4'b1 << g;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      g         <= 2'd0;
      lat_addr  <= '0;
      dout      <= 32'd0;
      we        <= 4'b0;
      sdram_req <= 1'b0;
    end else begin
      state     <= state_nxt;
      sdram_req <= sdram_req_nxt;
      we        <= we_nxt;
      case (state)
        IDLE: if (gnt_vld) begin
          g        <= gnt;
          lat_addr <= addr_arr[gnt][AW-1:2];
        end
        WAIT_LO: if (data_rdy) dout[15:0]  <= sdram_din;
        WAIT_HI: if (data_rdy) dout[31:16] <= sdram_din;
        DELIVER: ptr <= g + 2'd1;
        default: ;
      endcase
    end
  end

endmodule
